// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        CMP_IDLE,
        CMP_RUN
    } cmp_state_e;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_LT,
        DEC_GT
    } cmp_dec_e;

    function automatic int n_dig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit compare still needs a 1-bit index register.
    function automatic int idx_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_compare.sv
// Unsigned compare of one DIGIT-wide slice; flags A<B and A>B.
module digit_compare #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             dlt,
    output logic             dgt
);

    assign dlt = (a < b);
    assign dgt = (a > b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle.
// Signed operands are biased to unsigned by flipping the MSB at latch time.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int N_DIG = n_dig(WIDTH, DIGIT);
    localparam int IDX_W = idx_width(WIDTH, DIGIT);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_DIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    cmp_state_e       state_q;
    cmp_dec_e         dec_q;
    cmp_dec_e         dec_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;
    logic             dig_lt;
    logic             dig_gt;
    logic             finish_d;

    // Operands shift left each cycle, so the digit under test is always the top slice.
    digit_compare #(
        .DIGIT(DIGIT)
    ) u_digit_compare (
        .a  (a_q[WIDTH-1 -: DIGIT]),
        .b  (b_q[WIDTH-1 -: DIGIT]),
        .dlt(dig_lt),
        .dgt(dig_gt)
    );

    always_comb begin
        dec_d = dec_q;
        if (dec_q == DEC_NONE) begin
            if (dig_lt) begin
                dec_d = DEC_LT;
            end else if (dig_gt) begin
                dec_d = DEC_GT;
            end
        end
        finish_d = (idx_q == '0) ||
                   ((EARLY_EXIT != 0) && (dec_q == DEC_NONE) && (dig_lt || dig_gt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CMP_IDLE;
            dec_q   <= DEC_NONE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CMP_IDLE: begin
                    if (start) begin
                        a_q     <= signed_mode ? (a ^ MSB_MASK) : a;
                        b_q     <= signed_mode ? (b ^ MSB_MASK) : b;
                        idx_q   <= IDX_TOP;
                        dec_q   <= DEC_NONE;
                        busy_q  <= 1'b1;
                        state_q <= CMP_RUN;
                    end
                end
                CMP_RUN: begin
                    dec_q <= dec_d;
                    if (finish_d) begin
                        state_q <= CMP_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lt_q    <= (dec_d == DEC_LT);
                        gt_q    <= (dec_d == DEC_GT);
                        eq_q    <= (dec_d == DEC_NONE);
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        a_q   <= a_q << DIGIT;
                        b_q   <= b_q << DIGIT;
                    end
                end
                default: begin
                    state_q <= CMP_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: three comparator configurations, expected results from an arithmetic model.
module tb_serial_magnitude_comparator;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0] start_r = '0;
    logic [NI-1:0] sm_r    = '0;
    logic [7:0]    a_r [NI];
    logic [7:0]    b_r [NI];
    logic [NI-1:0] busy_w, done_w, lt_w, eq_w, gt_w;

    initial begin
        for (int j = 0; j < NI; j++) begin
            a_r[j] = 8'h00;
            b_r[j] = 8'h00;
        end
    end

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .signed_mode(sm_r[0]),
        .a(a_r[0]), .b(b_r[0]), .busy(busy_w[0]), .done(done_w[0]),
        .lt(lt_w[0]), .eq(eq_w[0]), .gt(gt_w[0]));

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .signed_mode(sm_r[1]),
        .a(a_r[1]), .b(b_r[1]), .busy(busy_w[1]), .done(done_w[1]),
        .lt(lt_w[1]), .eq(eq_w[1]), .gt(gt_w[1]));

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .signed_mode(sm_r[2]),
        .a(a_r[2]), .b(b_r[2]), .busy(busy_w[2]), .done(done_w[2]),
        .lt(lt_w[2]), .eq(eq_w[2]), .gt(gt_w[2]));

    typedef struct {
        int   inst;
        logic lt;
        logic eq;
        logic gt;
        int   cyc;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] last [NI];

    function automatic int dig_of(input int j);
        return (j == 2) ? 4 : 1;
    endfunction

    function automatic int ee_of(input int j);
        return (j == 1) ? 0 : 1;
    endfunction

    // k is the edge that samples start; done is expected to be visible after edge k+n.
    function automatic exp_t model(input int j, input logic [7:0] av, input logic [7:0] bv,
                                   input logic smv, input int k);
        exp_t e;
        int   sa, sb, dig, nd, n, x;
        bit   found;
        dig = dig_of(j);
        nd  = 8 / dig;
        sa  = smv ? int'($signed(av)) : int'(av);
        sb  = smv ? int'($signed(bv)) : int'(bv);
        e.inst = j;
        e.lt   = (sa < sb);
        e.eq   = (sa == sb);
        e.gt   = (sa > sb);
        n      = nd;
        found  = 1'b0;
        x      = int'(av ^ bv);
        if (ee_of(j) != 0) begin
            for (int i = 0; i < nd; i++) begin
                if (!found && (((x >> (8 - (i + 1) * dig)) & ((1 << dig) - 1)) != 0)) begin
                    n     = i + 1;
                    found = 1'b1;
                end
            end
        end
        e.cyc = k + n;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int j = 0; j < NI; j++) begin
                n_tests++;
                if ({busy_w[j], done_w[j], lt_w[j], eq_w[j], gt_w[j]} != 5'b00000) begin
                    n_fail++;
                    $display("FAIL reset inst%0d: busy,done,lt,eq,gt=%b%b%b%b%b required 00000",
                             j, busy_w[j], done_w[j], lt_w[j], eq_w[j], gt_w[j]);
                end
                last[j] = 3'b000;
            end
        end else begin
            for (int j = 0; j < NI; j++) begin
                if (done_w[j]) begin
                    n_tests++;
                    if (q.size() == 0 || q[0].inst != j) begin
                        n_fail++;
                        $display("FAIL unexpected_done inst%0d at cycle %0d: got done=1 required no done",
                                 j, cyc);
                    end else begin
                        e = q.pop_front();
                        if (cyc != e.cyc || busy_w[j]) begin
                            n_fail++;
                            $display("FAIL latency inst%0d: done at cycle %0d busy=%b, required cycle %0d busy=0",
                                     j, cyc, busy_w[j], e.cyc);
                        end
                        n_tests++;
                        if ({lt_w[j], eq_w[j], gt_w[j]} != {e.lt, e.eq, e.gt}) begin
                            n_fail++;
                            $display("FAIL result inst%0d: lt,eq,gt=%b%b%b required %b%b%b",
                                     j, lt_w[j], eq_w[j], gt_w[j], e.lt, e.eq, e.gt);
                        end
                    end
                    last[j] = {lt_w[j], eq_w[j], gt_w[j]};
                end else begin
                    n_tests++;
                    if ({lt_w[j], eq_w[j], gt_w[j]} != last[j]) begin
                        n_fail++;
                        $display("FAIL hold inst%0d: lt,eq,gt=%b%b%b changed without done, required %b",
                                 j, lt_w[j], eq_w[j], gt_w[j], last[j]);
                    end
                    if (q.size() > 0 && q[0].inst == j && cyc >= q[0].cyc) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL missing_done inst%0d: no done at cycle %0d, required done at %0d",
                                 j, cyc, q[0].cyc);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // All stimulus tasks are entered and left at negedge+1.
    task automatic wait_idle(input int j);
        for (int t = 0; t < 40; t++) begin
            if (q.size() == 0 && !busy_w[j]) break;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic issue(input int j, input logic [7:0] av, input logic [7:0] bv,
                         input logic smv, input bit push, input bit hold);
        a_r[j]     = av;
        b_r[j]     = bv;
        sm_r[j]    = smv;
        start_r[j] = 1'b1;
        if (push) q.push_back(model(j, av, bv, smv, cyc + 1));
        @(negedge clk);
        #1;
        if (!hold) start_r[j] = 1'b0;
    endtask

    int         d_inst [7] = '{0, 0, 0, 0, 1, 2, 2};
    logic [7:0] d_a    [7] = '{8'hA5, 8'h80, 8'h80, 8'h3C, 8'h80, 8'h12, 8'h12};
    logic [7:0] d_b    [7] = '{8'hA4, 8'h7F, 8'h7F, 8'h3C, 8'h00, 8'h1F, 8'h12};
    logic       d_sm   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        exp_t       e1;
        logic [7:0] av, bv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            wait_idle(d_inst[i]);
            issue(d_inst[i], d_a[i], d_b[i], d_sm[i], 1'b1, 1'b0);
        end

        // Reset mid-compare: no expectation queued, so any later done is flagged.
        wait_idle(0);
        issue(0, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;

        // start held high; a changes mid-run; second compare begins right after done.
        wait_idle(0);
        e1 = model(0, 8'h40, 8'h41, 1'b0, cyc + 1);
        issue(0, 8'h40, 8'h41, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        a_r[0] = 8'h90;
        q.push_back(model(0, 8'h90, 8'h41, 1'b0, e1.cyc + 1));
        for (int t = 0; t < 40; t++) begin
            if (cyc >= e1.cyc + 1) break;
            @(negedge clk);
            #1;
        end
        start_r[0] = 1'b0;

        for (int j = 0; j < NI; j++) begin
            for (int i = 0; i < 40; i++) begin
                av = 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       bv = av;
                    1:       bv = av ^ (8'd1 << $urandom_range(0, 7));
                    default: bv = 8'($urandom);
                endcase
                wait_idle(j);
                issue(j, av, bv, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end
        end

        wait_idle(0);
        wait_idle(1);
        wait_idle(2);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
